cmp_sweep_checker: RTL

Self-test driver and checker for the equality comparator. It generates every {x, y} operand combination and holds each long enough for the comparator to settle. It then samples the comparator's z result, checks it against the expected x == y, and reports a pass/fail verdict with an error count and the first failing vector. It sits on the driving side of the comparator interface and replaces the hand-written stimulus sequence with an exhaustive, self-checking hardware sweep.

---
 rtl/cmp_sweep_checker.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cmp_sweep_checker.sv
// Exhaustive self-test driver for an equality comparator: sweeps every {x, y} pair,
// holds each for HOLD_CYCLES, checks z against x == y and reports verdict/first failure.
module cmp_sweep_checker #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  input  logic             z_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] fail_x,
  output logic [WIDTH-1:0] fail_y
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned EW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [EW-1:0]    err_q, err_d;
  logic             pass_q, pass_d;
  logic [WIDTH-1:0] fail_x_q, fail_x_d;
  logic [WIDTH-1:0] fail_y_q, fail_y_d;
  logic             first_fail_q, first_fail_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             eq_c;
  logic             last_hold_c;
  logic             mismatch_c;

  assign x_out     = vec_q[VW-1:WIDTH];
  assign y_out     = vec_q[WIDTH-1:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_x    = fail_x_q;
  assign fail_y    = fail_y_q;

  assign eq_c        = (vec_q[VW-1:WIDTH] == vec_q[WIDTH-1:0]);
  assign last_hold_c = (hold_q == HW'(HOLD_CYCLES - 1));
  assign mismatch_c  = (z_in != eq_c);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      hold_q       <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      fail_x_q     <= '0;
      fail_y_q     <= '0;
      first_fail_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      fail_x_q     <= fail_x_d;
      fail_y_q     <= fail_y_d;
      first_fail_q <= first_fail_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic; busy/done/pass are computed one edge early so they are registered
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    hold_d       = hold_q;
    err_d        = err_q;
    pass_d       = pass_q;
    fail_x_d     = fail_x_q;
    fail_y_d     = fail_y_q;
    first_fail_d = first_fail_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_DRIVE;
          vec_d        = '0;
          hold_d       = '0;
          err_d        = '0;
          pass_d       = 1'b0;
          fail_x_d     = '0;
          fail_y_d     = '0;
          first_fail_d = 1'b0;
          busy_d       = 1'b1;
        end
      end

      S_DRIVE: begin
        hold_d = hold_q + HW'(1);
        if (last_hold_c) begin
          if (mismatch_c) begin
            if (err_q != {EW{1'b1}}) begin
              err_d = err_q + EW'(1);
            end
            if (!first_fail_q) begin
              fail_x_d     = vec_q[VW-1:WIDTH];
              fail_y_d     = vec_q[WIDTH-1:0];
              first_fail_d = 1'b1;
            end
          end
          if (&vec_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d  = vec_q + VW'(1);
            hold_d = '0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
